// File: rtl/sgmii_pkg.sv
// sgmii_pkg: shared K28.5 comma constants, alignment states and comma detector for the SGMII path
package sgmii_pkg;
  localparam int SYM_BITS = 10;
  localparam logic [SYM_BITS-1:0] K28_5_RDN = 10'h17C;
  localparam logic [SYM_BITS-1:0] K28_5_RDP = 10'h283;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} align_state_t;
  function automatic logic is_k28_5(input logic [SYM_BITS-1:0] s);
    return (s == K28_5_RDN) || (s == K28_5_RDP);
  endfunction
endpackage

// File: rtl/sgmii_rx_comma_align_if.sv
// sgmii_rx_comma_align_if: aligned 10b symbol stream and lock status toward the 8b/10b decoder
interface sgmii_rx_comma_align_if;
  import sgmii_pkg::*;
  logic [SYM_BITS-1:0] sym_data;
  logic sym_valid;
  logic sym_is_comma;
  logic sym_comma_rdp;
  logic locked;
  logic realign;
  modport master (output sym_data, sym_valid, sym_is_comma, sym_comma_rdp, locked, realign);
  modport slave (input sym_data, sym_valid, sym_is_comma, sym_comma_rdp, locked, realign);
endinterface

// File: rtl/sgmii_rx_comma_align.sv
// sgmii_rx_comma_align: serial-to-parallel SGMII receive front end with K28.5 comma hunt and lock tracking
module sgmii_rx_comma_align
  import sgmii_pkg::*;
#(
  parameter int LOCK_COMMAS   = 3,
  parameter int MISALIGN_MAX  = 2,
  parameter int COMMA_TIMEOUT = 1024
) (
  input  logic                          ser_sgmii_clk,
  input  logic                          reset,
  input  logic                          sgmii_rx_p,
  sgmii_rx_comma_align_if.master        sym
);
  localparam int TW = $clog2(COMMA_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_COMMAS + 1);
  localparam int MW = $clog2(MISALIGN_MAX + 1);
  logic [SYM_BITS-1:0] sr;
  logic [3:0] ph;
  align_state_t state;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [MW-1:0] mis_cnt, mis_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic match, boundary, acquire, emit;
  assign match    = is_k28_5(sr);
  assign boundary = (state != HUNT) && (ph == 4'd9);
  // a comma off the symbol grid restarts alignment only while not yet locked
  assign acquire  = match && ((state == HUNT) || (state == VERIFY && !boundary));
  assign emit     = boundary || acquire;
  assign good_nxt = good_cnt + GW'(1);
  assign mis_nxt  = mis_cnt + MW'(1);
  assign tmo_nxt  = tmo_cnt + TW'(1);
  assign sym.locked = state == LOCKED;
  always_ff @(posedge ser_sgmii_clk) begin
    if (reset) begin
      sr                <= '0;
      ph                <= '0;
      state             <= HUNT;
      good_cnt          <= '0;
      mis_cnt           <= '0;
      tmo_cnt           <= '0;
      sym.sym_data      <= '0;
      sym.sym_valid     <= 1'b0;
      sym.sym_is_comma  <= 1'b0;
      sym.sym_comma_rdp <= 1'b0;
      sym.realign       <= 1'b0;
    end else begin
      sr            <= {sr[SYM_BITS-2:0], sgmii_rx_p};
      ph            <= (acquire || ph == 4'd9) ? 4'd0 : ph + 4'd1;
      sym.realign   <= acquire;
      sym.sym_valid <= emit;
      if (emit) begin
        sym.sym_data      <= sr;
        sym.sym_is_comma  <= match;
        sym.sym_comma_rdp <= sr == K28_5_RDP;
      end
      if (acquire) begin
        good_cnt <= GW'(1);
        mis_cnt  <= '0;
        tmo_cnt  <= '0;
        state    <= (LOCK_COMMAS == 1) ? LOCKED : VERIFY;
      end else if (state == VERIFY && boundary && match) begin
        good_cnt <= good_nxt;
        if (good_nxt == GW'(LOCK_COMMAS)) begin
          state   <= LOCKED;
          mis_cnt <= '0;
          tmo_cnt <= '0;
        end
      end else if (state == LOCKED) begin
        if (boundary && match) begin
          mis_cnt <= '0;
          tmo_cnt <= '0;
        end else if (boundary) begin
          tmo_cnt <= tmo_nxt;
          if (tmo_nxt == TW'(COMMA_TIMEOUT)) state <= HUNT;
        end else if (match) begin
          mis_cnt <= mis_nxt;
          if (mis_nxt == MW'(MISALIGN_MAX)) begin
            state <= HUNT;
            ph    <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sgmii_rx_comma_align.sv
// tb_sgmii_rx_comma_align: directed comma hunt, lock, misalign, timeout and reset checks
module tb_sgmii_rx_comma_align;
  import sgmii_pkg::*;
  localparam logic [9:0] D16_2 = 10'h2B6;
  localparam logic [11:0] L_RDN = 12'h57C;
  localparam logic [11:0] L_RDP = 12'hE83;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_realign = 0;
  int rl_cyc = 0;
  int c0 = 0;
  logic [11:0] log_q[$];
  int cyc_q[$];
  sgmii_rx_comma_align_if sym_if();
  sgmii_rx_comma_align dut (
    .ser_sgmii_clk(clk),
    .reset(rst),
    .sgmii_rx_p(rx),
    .sym(sym_if)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic b);
    rx = b;
    @(posedge clk);
    #1;
    cyc++;
    if (sym_if.sym_valid) begin
      log_q.push_back({sym_if.sym_comma_rdp, sym_if.sym_is_comma, sym_if.sym_data});
      cyc_q.push_back(cyc);
    end
    if (sym_if.realign) begin
      n_realign++;
      rl_cyc = cyc;
    end
  endtask
  task automatic send_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) tick(s[i]);
  endtask
  task automatic clear_log();
    log_q.delete();
    cyc_q.delete();
    n_realign = 0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
  endtask
  task automatic garbage();
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
  endtask
  initial begin
    do_reset();
    check("rst_valid", sym_if.sym_valid, 0);
    check("rst_data", sym_if.sym_data, 0);
    check("rst_locked", sym_if.locked, 0);
    check("rst_realign", sym_if.realign, 0);
    clear_log();
    for (int i = 0; i < 50; i++) tick(1'b0);
    check("idle_nsym", log_q.size(), 0);
    check("idle_locked", sym_if.locked, 0);
    check("idle_realign", n_realign, 0);
    clear_log();
    c0 = cyc;
    garbage();
    send_sym(K28_5_RDN);
    send_sym(K28_5_RDP);
    send_sym(K28_5_RDN);
    check("lock_early", sym_if.locked, 0);
    send_sym(K28_5_RDP);
    check("lock_3rd", sym_if.locked, 1);
    check("acq_nsym", log_q.size(), 3);
    check("acq_sym0", log_q[0], L_RDN);
    check("acq_sym1", log_q[1], L_RDP);
    check("acq_sym2", log_q[2], L_RDN);
    check("acq_cyc0", cyc_q[0] - c0, 14);
    check("acq_gap1", cyc_q[1] - cyc_q[0], 10);
    check("acq_gap2", cyc_q[2] - cyc_q[1], 10);
    check("acq_realign", n_realign, 1);
    check("acq_realign_cyc", rl_cyc - c0, 14);
    clear_log();
    send_sym(K28_5_RDN);
    send_sym(D16_2);
    send_sym(K28_5_RDN);
    send_sym(D16_2);
    check("pair_nsym", log_q.size(), 4);
    check("pair_c4", log_q[0], L_RDP);
    check("pair_data", log_q[2], {2'b00, D16_2});
    clear_log();
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    send_sym(K28_5_RDN);
    send_sym(D16_2);
    check("mis1_locked", sym_if.locked, 1);
    check("mis1_noreal", n_realign, 0);
    check("mis1_nsym", log_q.size(), 3);
    check("mis1_slip0", log_q[1], 12'h297);
    check("mis1_slip1", log_q[2], 12'h32B);
    send_sym(K28_5_RDN);
    check("mis2_pre", sym_if.locked, 1);
    send_sym(D16_2);
    check("mis2_drop", sym_if.locked, 0);
    check("mis2_noreal", n_realign, 0);
    clear_log();
    send_sym(K28_5_RDN);
    send_sym(D16_2);
    check("reacq_real", n_realign, 1);
    check("reacq_nsym", log_q.size(), 1);
    check("reacq_sym", log_q[0], L_RDN);
    check("reacq_unlocked", sym_if.locked, 0);
    do_reset();
    garbage();
    send_sym(K28_5_RDN);
    send_sym(K28_5_RDP);
    send_sym(K28_5_RDN);
    for (int i = 0; i < 1023; i++) send_sym(D16_2);
    send_sym(K28_5_RDN);
    check("tmo_1023_hold", sym_if.locked, 1);
    for (int i = 0; i < 1024; i++) send_sym(D16_2);
    check("tmo_pre", sym_if.locked, 1);
    tick(1'b0);
    check("tmo_drop", sym_if.locked, 0);
    do_reset();
    garbage();
    send_sym(K28_5_RDN);
    send_sym(K28_5_RDP);
    tick(1'b0);
    clear_log();
    send_sym(K28_5_RDN);
    send_sym(K28_5_RDP);
    check("vslip_real", n_realign, 1);
    check("vslip_nsym", log_q.size(), 2);
    check("vslip_nc", log_q[0], 12'h0BE);
    check("vslip_c", log_q[1], L_RDN);
    send_sym(K28_5_RDN);
    check("vslip_nolock", sym_if.locked, 0);
    tick(1'b0);
    check("vslip_lock", sym_if.locked, 1);
    do_reset();
    garbage();
    send_sym(K28_5_RDN);
    send_sym(K28_5_RDP);
    send_sym(K28_5_RDN);
    send_sym(K28_5_RDP);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    check("mid_locked", sym_if.locked, 1);
    check("mid_data", sym_if.sym_data, 10'h283);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    check("mrst_data", sym_if.sym_data, 0);
    check("mrst_valid", sym_if.sym_valid, 0);
    check("mrst_comma", sym_if.sym_is_comma, 0);
    check("mrst_rdp", sym_if.sym_comma_rdp, 0);
    check("mrst_locked", sym_if.locked, 0);
    check("mrst_realign", sym_if.realign, 0);
    clear_log();
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    send_sym(K28_5_RDP);
    send_sym(K28_5_RDN);
    check("mrst_relock1", sym_if.locked, 0);
    send_sym(K28_5_RDP);
    check("mrst_relock2", sym_if.locked, 0);
    tick(1'b0);
    check("mrst_relock3", sym_if.locked, 1);
    check("mrst_real", n_realign, 1);
    check("mrst_nsym", log_q.size(), 3);
    check("mrst_sym0", log_q[0], L_RDP);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
